// File: rtl/branch_predictor.sv
// Branch predictor for the fetch stage: a direct-mapped BTB and a BHT of
// 2-bit saturating counters. The BHT is indexed by PC (bimodal) or by PC
// XOR global history (gshare). The prediction is purely combinational.
// Updates from EX are written at the clock edge, so they become visible
// on the following cycle.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 32,
  parameter int MODE     = 0,
  parameter int GHR_BITS = 5,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [IDX-1:0]  pred_bht_idx,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [IDX-1:0]  upd_bht_idx,
  input  logic            upd_is_branch,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     mispredict_count
);

  localparam int TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]    btb_tag    [ENTRIES];
  logic [XLEN-1:0]    btb_target [ENTRIES];
  logic [1:0]         bht        [ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  logic [IDX-1:0]  fetch_idx;
  logic [TAGW-1:0] fetch_tag;
  logic [IDX-1:0]  ghr_ext;
  logic [IDX-1:0]  bht_idx;
  logic            hit;
  logic [1:0]      fetch_ctr;

  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic [1:0]      upd_ctr_next;
  logic [GHR_BITS:0] ghr_shift;

  // The low two PC bits of a resolved instruction never select anything.
  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^upd_pc[1:0];

  assign fetch_idx = if_pc[IDX+1:2];
  assign fetch_tag = if_pc[XLEN-1:IDX+2];
  assign upd_idx   = upd_pc[IDX+1:2];
  assign upd_tag   = upd_pc[XLEN-1:IDX+2];
  assign ghr_shift = {ghr, upd_taken};

  // Zero-extend the global history to the index width.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = ghr;
  end

  // Fetch-side lookup, reading only registered state (no path from upd_*).
  always_comb begin
    bht_idx      = (MODE == 1) ? (fetch_idx ^ ghr_ext) : fetch_idx;
    hit          = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    fetch_ctr    = bht[bht_idx];
    pred_taken   = hit && fetch_ctr[1];
    pred_target  = pred_taken ? btb_target[fetch_idx] : (if_pc + XLEN'(4));
    pred_bht_idx = bht_idx;
  end

  // Next counter value: jumps force strongly-taken, branches step and saturate.
  always_comb begin
    upd_ctr_next = bht[upd_bht_idx];
    if (!upd_is_branch) begin
      upd_ctr_next = 2'b11;
    end else if (upd_taken) begin
      if (bht[upd_bht_idx] != 2'b11) upd_ctr_next = bht[upd_bht_idx] + 2'd1;
    end else begin
      if (bht[upd_bht_idx] != 2'b00) upd_ctr_next = bht[upd_bht_idx] - 2'd1;
    end
  end

  // BTB valid bits; a taken resolution allocates, overwriting any alias.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  // BTB payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken && !reset) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
    end
  end

  // BHT counters start weakly not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      bht[upd_bht_idx] <= upd_ctr_next;
    end
  end

  // Non-speculative global history, shifted by conditional branches only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_valid && upd_is_branch) begin
      ghr <= ghr_shift[GHR_BITS-1:0];
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (upd_valid && upd_mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal instance (dut0) and a gshare instance (dut1)
// share all inputs. Expected values are hand-computed.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_bht_idx;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        pred_taken0, pred_taken1;
  logic [31:0] pred_target0, pred_target1;
  logic [3:0]  pred_bht_idx0, pred_bht_idx1;
  logic [31:0] mcount0, mcount1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_mc;
  logic [3:0]  ghr_m;
  logic [3:0]  idx_m;
  logic        t;
  logic        misp;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(0), .GHR_BITS(4)) dut0 (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken0), .pred_target(pred_target0), .pred_bht_idx(pred_bht_idx0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_bht_idx(upd_bht_idx),
    .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mcount0)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(1), .GHR_BITS(4)) dut1 (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken1), .pred_target(pred_target1), .pred_bht_idx(pred_bht_idx1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_bht_idx(upd_bht_idx),
    .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mcount1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] idx, input logic br,
                     input logic tk, input logic [31:0] tgt, input logic mp);
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_bht_idx    = idx;
    upd_is_branch  = br;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mp;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    if (mp) exp_mc = exp_mc + 32'd1;
  endtask

  task automatic predict0(input string tag, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken0}, {31'd0, exp_tk});
    check({tag, "_target"}, pred_target0, exp_tgt);
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'h40;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_bht_idx = '0;
    upd_is_branch = 1'b0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_mispredict = 1'b0;
    exp_mc = '0;
    ghr_m = '0;

    #2;
    predict0("in_reset", 32'h40, 1'b0, 32'h44);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Post-reset defaults and PC+4 wrap.
    predict0("rst", 32'h40, 1'b0, 32'h44);
    check("rst_mc", mcount0, 32'd0);
    check("rst_idx", {28'd0, pred_bht_idx0}, 32'd0);
    predict0("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // First taken update; same-cycle lookup must still see old state.
    @(negedge clk);
    if_pc = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_bht_idx = 4'd0; upd_is_branch = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h20; upd_mispredict = 1'b1;
    #1;
    check("same_cycle_taken", {31'd0, pred_taken0}, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    exp_mc = exp_mc + 32'd1;
    predict0("learn", 32'h40, 1'b1, 32'h20);
    check("learn_mc", mcount0, exp_mc);

    // Two not-taken: 10 -> 01 -> 00.
    upd(32'h40, 4'd0, 1'b1, 1'b0, 32'h0, 1'b1);
    upd(32'h40, 4'd0, 1'b1, 1'b0, 32'h0, 1'b1);
    predict0("nt2", 32'h40, 1'b0, 32'h44);
    check("nt2_mc", mcount0, exp_mc);

    // Update fields without upd_valid must be ignored.
    @(negedge clk);
    upd_pc = 32'h40; upd_bht_idx = 4'd0; upd_is_branch = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h300; upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    predict0("novalid", 32'h40, 1'b0, 32'h44);
    check("novalid_mc", mcount0, exp_mc);

    // Retrain to 10, then aliasing PC 0x80 on the same index.
    upd(32'h40, 4'd0, 1'b1, 1'b1, 32'h20, 1'b0);
    upd(32'h40, 4'd0, 1'b1, 1'b1, 32'h20, 1'b0);
    predict0("retrain", 32'h40, 1'b1, 32'h20);
    predict0("alias_miss", 32'h80, 1'b0, 32'h84);
    upd(32'h80, 4'd0, 1'b1, 1'b1, 32'h100, 1'b1);
    predict0("evict_new", 32'h80, 1'b1, 32'h100);
    predict0("evict_old", 32'h40, 1'b0, 32'h44);

    // Saturation at 11, one not-taken drops to 10, still taken.
    for (int i = 0; i < 5; i++) upd(32'h80, 4'd0, 1'b1, 1'b1, 32'h100, 1'b0);
    upd(32'h80, 4'd0, 1'b1, 1'b0, 32'h0, 1'b1);
    predict0("sat_nt", 32'h80, 1'b1, 32'h100);
    check("sat_mc", mcount0, exp_mc);

    // jal at 0x60 (index 8) forces counter 11.
    predict0("jal_before", 32'h60, 1'b0, 32'h64);
    check("jal_idx", {28'd0, pred_bht_idx0}, 32'd8);
    upd(32'h60, 4'd8, 1'b0, 1'b1, 32'h200, 1'b0);
    predict0("jal_after", 32'h60, 1'b1, 32'h200);

    // Asynchronous reset between edges; an update during reset is ignored.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_mc0", mcount0, 32'd0);
    predict0("async_rst", 32'h80, 1'b0, 32'h84);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_bht_idx = 4'd0; upd_is_branch = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h20; upd_mispredict = 1'b1;
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    reset = 1'b0;
    exp_mc = '0;
    predict0("rst_upd_ignored", 32'h40, 1'b0, 32'h44);
    check("rst_upd_mc", mcount0, 32'd0);

    // gshare: alternating T/N at 0x40. Mispredicts occur at steps 0, 2, 4.
    for (int s = 0; s < 10; s++) begin
      t = (s % 2 == 0);
      misp = (s == 0) || (s == 2) || (s == 4);
      idx_m = 4'd0 ^ ghr_m;
      if_pc = 32'h40;
      #1;
      if (s >= 6) begin
        check("gs_idx", {28'd0, pred_bht_idx1}, t ? 32'd10 : 32'd5);
        check("gs_taken", {31'd0, pred_taken1}, {31'd0, t});
        check("gs_target", pred_target1, t ? 32'h20 : 32'h44);
      end
      upd(32'h40, idx_m, 1'b1, t, 32'h20, misp);
      ghr_m = {ghr_m[2:0], t};
    end
    check("gs_mc3", mcount1, 32'd3);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("gs_async_mc", mcount1, 32'd0);
    check("gs_async_taken", {31'd0, pred_taken1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
